// File: rtl/vend_coin_input_if.sv
// Coin-slot bus: raw slot switches in, clean coin codes and stuck flags out.
interface vend_coin_input_if;
  logic       Key_half;
  logic       Key_one;
  logic [1:0] D_in;
  logic [1:0] Stuck;

  // Slot side: drives the raw switches, observes codes and stuck flags.
  modport master (
    output Key_half,
    output Key_one,
    input  D_in,
    input  Stuck
  );

  // Front end side: receives raw switches, produces codes and stuck flags.
  modport slave (
    input  Key_half,
    input  Key_one,
    output D_in,
    output Stuck
  );
endinterface

// File: rtl/vend_coin_input.sv
// Coin input front end: synchronises and debounces the two coin-slot
// switches, merges accepted presses into one-cycle coin codes separated
// by at least one idle cycle, and flags a slot switch that stays pressed.
module vend_coin_input #(
  parameter int DEB_CYCLES   = 4,
  parameter int STUCK_CYCLES = 1000
) (
  input logic              Clk,
  input logic              Reset,
  vend_coin_input_if.slave bus
);

  // Counter is shared between debounce and stuck timing; stuck is the larger.
  localparam int CW = $clog2(STUCK_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] STK_MAX  = CW'(STUCK_CYCLES);
  localparam logic [CW-1:0] STK_LAST = CW'(STUCK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } key_state_t;

  typedef enum logic {
    EMIT_IDLE = 1'b0,
    GAP       = 1'b1
  } emit_state_t;

  // Bit 0 is the half-unit slot, bit 1 the one-unit slot throughout.
  logic [1:0]    raw_s;
  logic [1:0]    sync1_r;
  logic [1:0]    sync2_r;
  key_state_t    key_state_r [2];
  logic [CW-1:0] cnt_r [2];
  logic [1:0]    stuck_r;
  logic [1:0]    acc_s;
  logic [1:0]    pend_r;
  logic [1:0]    d_in_r;
  emit_state_t   emit_state_r;

  assign raw_s     = {bus.Key_one, bus.Key_half};
  assign bus.D_in  = d_in_r;
  assign bus.Stuck = stuck_r;

  // Two-flop synchroniser per slot; only sync2_r is used downstream.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // A press is accepted on the edge its debounce count completes.
  always_comb begin
    acc_s = 2'b00;
    for (int k = 0; k < 2; k++) begin
      acc_s[k] = (key_state_r[k] == PRESS_DB) && sync2_r[k] && (cnt_r[k] == DEB_LAST);
    end
  end

  // Per-slot debounce / hold / stuck state machine.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < 2; k++) begin
        key_state_r[k] <= IDLE;
        cnt_r[k]       <= CNT_ZERO;
      end
      stuck_r <= 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        case (key_state_r[k])
          IDLE: begin
            if (sync2_r[k]) begin
              key_state_r[k] <= PRESS_DB;
              cnt_r[k]       <= CNT_ONE;
            end else begin
              cnt_r[k] <= CNT_ZERO;
            end
          end
          PRESS_DB: begin
            if (!sync2_r[k]) begin
              key_state_r[k] <= IDLE;
              cnt_r[k]       <= CNT_ZERO;
            end else if (cnt_r[k] == DEB_LAST) begin
              // Press accepted; the hold count starts from zero.
              key_state_r[k] <= HELD;
              cnt_r[k]       <= CNT_ZERO;
            end else begin
              cnt_r[k] <= cnt_r[k] + CNT_ONE;
            end
          end
          HELD: begin
            if (!sync2_r[k]) begin
              key_state_r[k] <= RELEASE_DB;
              cnt_r[k]       <= CNT_ONE;
            end else if (cnt_r[k] != STK_MAX) begin
              cnt_r[k] <= cnt_r[k] + CNT_ONE;
              if (cnt_r[k] == STK_LAST) begin
                stuck_r[k] <= 1'b1;
              end else begin
                stuck_r[k] <= stuck_r[k];
              end
            end else begin
              cnt_r[k] <= cnt_r[k];
            end
          end
          RELEASE_DB: begin
            if (sync2_r[k]) begin
              // Release bounced: back to hold without re-accepting the coin.
              key_state_r[k] <= HELD;
              cnt_r[k]       <= CNT_ZERO;
            end else if (cnt_r[k] == DEB_LAST) begin
              key_state_r[k] <= IDLE;
              cnt_r[k]       <= CNT_ZERO;
              stuck_r[k]     <= 1'b0;
            end else begin
              cnt_r[k] <= cnt_r[k] + CNT_ONE;
            end
          end
          default: begin
            key_state_r[k] <= IDLE;
            cnt_r[k]       <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  // Emit pending coins as one-cycle codes, each followed by a 00 gap cycle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      emit_state_r <= EMIT_IDLE;
      pend_r       <= 2'b00;
      d_in_r       <= 2'b00;
    end else begin
      case (emit_state_r)
        EMIT_IDLE: begin
          if (pend_r != 2'b00) begin
            // Consume both pend bits; a press accepted this edge survives.
            d_in_r       <= pend_r;
            pend_r       <= acc_s;
            emit_state_r <= GAP;
          end else begin
            d_in_r <= 2'b00;
            pend_r <= acc_s;
          end
        end
        GAP: begin
          d_in_r       <= 2'b00;
          pend_r       <= pend_r | acc_s;
          emit_state_r <= EMIT_IDLE;
        end
        default: begin
          d_in_r       <= 2'b00;
          pend_r       <= 2'b00;
          emit_state_r <= EMIT_IDLE;
        end
      endcase
    end
  end

endmodule
